ram_block_mover: RTL and testbench
==================================

RAM_BLOCK_MOVER -- requirements
Module: ram_block_mover

Interface
REQ-001 The block SHALL expose one parameter: ADDR_WIDTH, default 9, RAM address width; all address and length arithmetic is modulo 2^ADDR_WIDTH.
REQ-002 The block SHALL have port clk, input, width 1: single clock, all state changes on rising edge.
REQ-003 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, width 1: request a transfer; sampled only in IDLE.
REQ-005 The block SHALL have port mode, input, width 1: 0 = copy, 1 = fill.
REQ-006 The block SHALL have port src_address, input, width ADDR_WIDTH: copy source start address.
REQ-007 The block SHALL have port dst_address, input, width ADDR_WIDTH: destination start address.
REQ-008 The block SHALL have port length, input, width ADDR_WIDTH: byte count; 0 means no transfer.
REQ-009 The block SHALL have port fill_value, input, width 8: byte written in fill mode.
REQ-010 The block SHALL have port busy, output, width 1: high in any state other than IDLE.
REQ-011 The block SHALL have port done, output, width 1: single-cycle completion pulse.
REQ-012 The block SHALL have port ram_address, output, width ADDR_WIDTH: RAM address.
REQ-013 The block SHALL have port ram_data_in, output, width 8: write data to RAM.
REQ-014 The block SHALL have port ram_data_out, input, width 8: RAM read data, combinational (valid in the same cycle as ram_address).
REQ-015 The block SHALL have port ram_write_enable, output, width 1: RAM write strobe, sampled by RAM on rising clk.

Function
REQ-016 The block SHALL implement states IDLE, READ, WRITE, DONE; transitions occur on rising clk only.
REQ-017 In IDLE with start=1, the block SHALL latch src_address, dst_address, length, mode and fill_value. Next state: DONE if length=0, else WRITE if mode=1, else READ.
REQ-018 In READ, the block SHALL drive ram_address=current source pointer and ram_write_enable=0, capture ram_data_out into an 8-bit hold register at the clock edge, increment the source pointer, and go to WRITE.
REQ-019 In WRITE, the block SHALL drive ram_address=current destination pointer, ram_data_in=hold register (copy) or latched fill_value (fill), and ram_write_enable=1.
REQ-020 At the end of each WRITE, the block SHALL increment the destination pointer and decrement the remaining count. If the count becomes 0, go to DONE; else go to READ (copy) or stay in WRITE (fill).
REQ-021 In DONE, the block SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-022 Pointers SHALL wrap from 2^ADDR_WIDTH-1 to 0 without error.
REQ-023 Copy SHALL always proceed in ascending address order. Overlapping regions with dst>src propagate source bytes; this is the specified behaviour.
REQ-024 start asserted while busy=1 SHALL be ignored, with no queuing. Input changes after the latch cycle SHALL have no effect.
REQ-025 Latency from the start-sampling edge to the done cycle SHALL be N+1 cycles for fill and 2N+1 cycles for copy (N=length), and 1 cycle for length=0.
REQ-026 In IDLE and DONE, the block SHALL drive ram_write_enable=0, ram_address=0 and ram_data_in=0.
REQ-027 ram_write_enable and ram_address SHALL be decoded from registered state only, never combinationally from start.

Reset
REQ-028 While reset=1, the block SHALL force state=IDLE, zero pointers, count and hold register, and set busy=0, done=0, ram_write_enable=0, ram_address=0 and ram_data_in=0 immediately, without waiting for clk.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer: no further writes occur, bytes already written remain, and no done pulse is produced.
REQ-030 After reset deasserts, the block SHALL accept start on the first rising clk edge.

Verification
REQ-031 The bench SHALL cover fill: mode=1, dst=0x010, length=4, fill_value=0xA5. Required: write strobes at 0x010-0x013 on 4 consecutive cycles, done in cycle 5, RAM reads back 0xA5 x4.
REQ-032 The bench SHALL cover copy: RAM[0x040..0x042]=0x01,0x02,0x03, src=0x040, dst=0x100, length=3. Required: alternating READ/WRITE, done in cycle 7, RAM[0x100..0x102]=0x01,0x02,0x03.
REQ-033 The bench SHALL cover wrap: fill dst=0x1FE, length=3, value 0x5A. Required: writes to 0x1FE, 0x1FF, 0x000 only.
REQ-034 The bench SHALL cover zero length and busy start: length=0 gives done one cycle after start and no write strobe. A start pulse during a busy copy changes nothing.
REQ-035 The bench SHALL cover overlap: RAM[0x020]=0x11, copy src=0x020, dst=0x021, length=3. Required: RAM[0x021..0x023]=0x11.
REQ-036 The bench SHALL cover reset mid-operation: reset asserted after 2 of 8 fill writes. Required: ram_write_enable low before the next edge, only 2 bytes modified, busy=0, no done pulse.

Source files
------------

// File: rtl/ram_block_mover_if.sv
// Control and RAM-side signal bundle for the RAM block mover.
// The slave modport is the mover; the master modport is whoever issues
// transfers and owns the RAM (it supplies combinational read data).
interface ram_block_mover_if #(
    parameter int ADDR_WIDTH = 9
);
    // transfer request
    logic                  start;
    logic                  mode;
    logic [ADDR_WIDTH-1:0] src_address;
    logic [ADDR_WIDTH-1:0] dst_address;
    logic [ADDR_WIDTH-1:0] length;
    logic [7:0]            fill_value;
    // status
    logic                  busy;
    logic                  done;
    // RAM port
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [7:0]            ram_data_in;
    logic [7:0]            ram_data_out;
    logic                  ram_write_enable;

    modport master (
        output start, mode, src_address, dst_address, length, fill_value, ram_data_out,
        input  busy, done, ram_address, ram_data_in, ram_write_enable
    );

    modport slave (
        input  start, mode, src_address, dst_address, length, fill_value, ram_data_out,
        output busy, done, ram_address, ram_data_in, ram_write_enable
    );
endinterface

// File: rtl/ram_block_mover.sv
// RAM block mover: copies (read/write alternating) or fills a block of
// bytes in a single-port RAM with combinational read data. Addresses and
// counts wrap modulo 2^ADDR_WIDTH. All RAM-side outputs are decoded from
// registered state only, so an asynchronous reset silences them at once.
module ram_block_mover #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic              clk,
    input  logic              reset,
    ram_block_mover_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]            hold_q, hold_d;
    logic [7:0]            fill_q, fill_d;
    logic                  mode_q, mode_d;

    // Next-state: latch request in IDLE, step pointers/count per READ/WRITE
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        fill_d  = fill_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d  = bus.src_address;
                    dst_d  = bus.dst_address;
                    cnt_d  = bus.length;
                    mode_d = bus.mode;
                    fill_d = bus.fill_value;
                    if (bus.length == '0)  state_d = DONE;
                    else if (bus.mode)     state_d = WRITE;
                    else                   state_d = READ;
                end
            end
            READ: begin
                hold_d  = bus.ram_data_out;
                src_d   = src_q + ONE;
                state_d = WRITE;
            end
            WRITE: begin
                dst_d = dst_q + ONE;
                cnt_d = cnt_q - ONE;
                // last byte when the count is about to reach zero
                if (cnt_q == ONE)  state_d = DONE;
                else if (mode_q)   state_d = WRITE;
                else               state_d = READ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any transfer in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            fill_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            fill_q  <= fill_d;
            mode_q  <= mode_d;
        end
    end

    // Output decode from registered state; IDLE/DONE park the RAM bus at zero
    always_comb begin
        bus.busy             = (state_q != IDLE);
        bus.done             = (state_q == DONE);
        bus.ram_address      = '0;
        bus.ram_data_in      = 8'h00;
        bus.ram_write_enable = 1'b0;
        case (state_q)
            READ: bus.ram_address = src_q;
            WRITE: begin
                bus.ram_address      = dst_q;
                bus.ram_data_in      = mode_q ? fill_q : hold_q;
                bus.ram_write_enable = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ram_block_mover.sv
// Directed bench for ram_block_mover: a byte-array RAM model, a reference
// memory image, and a queue of expected writes popped as strobes appear.
module tb_ram_block_mover;
    logic clk;
    logic reset;

    ram_block_mover_if #(.ADDR_WIDTH(9)) bus ();

    ram_block_mover #(.ADDR_WIDTH(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [8:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] ram [512];
    logic [7:0] mdl [512];
    logic       tb_clr, tb_we;
    logic [8:0] tb_a;
    logic [7:0] tb_d;
    int         checks = 0;
    int         failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: bench backdoor writes, else DUT writes
    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 512; i++) ram[i] <= 8'h00;
        end else if (tb_we) begin
            ram[tb_a] <= tb_d;
        end else if (bus.ram_write_enable) begin
            ram[bus.ram_address] <= bus.ram_data_in;
        end
    end

    assign bus.ram_data_out = ram[bus.ram_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the head of the expected-write queue
    always @(negedge clk) begin
        if (bus.ram_write_enable) begin
            chk("wr_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.ram_address), 32'(e.a));
                chk("wr_data", 32'(bus.ram_data_in), 32'(e.d));
            end
        end
    end

    task automatic poke(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_a = a; tb_d = d;
        mdl[a] = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic mem_check(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 512; i++) if (ram[i] !== mdl[i]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic run_op(input logic m, input logic [8:0] s, input logic [8:0] d,
                          input logic [8:0] n, input logic [7:0] f,
                          input int exp_lat, input bit glitch, input string tag);
        int lat;
        bit seen;
        // reference model, ascending order so overlaps propagate
        for (int i = 0; i < int'(n); i++) begin
            logic [8:0] sa, da;
            logic [7:0] v;
            sa = s + 9'(i);
            da = d + 9'(i);
            v  = m ? f : mdl[sa];
            mdl[da] = v;
            sb.push_back({da, v});
        end
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.src_address = s;
        bus.dst_address = d; bus.length = n; bus.fill_value = f;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (glitch && lat == 2) begin
                bus.start = 1'b1; bus.mode = 1'b1; bus.src_address = 9'h1F0;
                bus.dst_address = 9'h000; bus.length = 9'd5; bus.fill_value = 8'hEE;
            end
            if (glitch && lat == 3) bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_done_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_done_bus"}, {bus.ram_write_enable, bus.ram_data_in, 14'h0, bus.ram_address}, 32'd0);
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, bus.done, bus.busy}, 32'd0);
        chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
        mem_check({tag, "_mem"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset = 1'b1;
        tb_clr = 1'b1; tb_we = 1'b0; tb_a = '0; tb_d = '0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.src_address = '0;
        bus.dst_address = '0; bus.length = '0; bus.fill_value = '0;
        for (int i = 0; i < 512; i++) mdl[i] = 8'h00;
        #1;
        chk("rst_outputs", {bus.busy, bus.done, bus.ram_write_enable, bus.ram_data_in, 12'h0, bus.ram_address}, 32'd0);
        @(negedge clk);
        tb_clr = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;

        poke(9'h040, 8'h01);
        poke(9'h041, 8'h02);
        poke(9'h042, 8'h03);
        poke(9'h020, 8'h11);

        run_op(1'b1, 9'h000, 9'h010, 9'd4, 8'hA5, 5, 1'b0, "fill");
        chk("fill_rd", 32'(ram[9'h013]), 32'h0A5);
        run_op(1'b0, 9'h040, 9'h100, 9'd3, 8'h00, 7, 1'b0, "copy");
        chk("copy_rd", 32'(ram[9'h102]), 32'h03);
        run_op(1'b1, 9'h000, 9'h1FE, 9'd3, 8'h5A, 4, 1'b0, "wrap");
        chk("wrap_rd0", 32'(ram[9'h000]), 32'h5A);
        run_op(1'b0, 9'h040, 9'h0AA, 9'd0, 8'h77, 1, 1'b0, "zero_copy");
        run_op(1'b1, 9'h040, 9'h0AA, 9'd0, 8'h77, 1, 1'b0, "zero_fill");
        run_op(1'b0, 9'h040, 9'h140, 9'd3, 8'h00, 7, 1'b1, "busy_start");
        run_op(1'b0, 9'h020, 9'h021, 9'd3, 8'h00, 7, 1'b0, "overlap");
        chk("overlap_rd", 32'(ram[9'h023]), 32'h11);

        // reset after two of eight fill writes
        mdl[9'h080] = 8'h3C; sb.push_back({9'h080, 8'h3C});
        mdl[9'h081] = 8'h3C; sb.push_back({9'h081, 8'h3C});
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b1; bus.dst_address = 9'h080;
        bus.length = 9'd8; bus.fill_value = 8'h3C;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_outputs", {bus.busy, bus.done, bus.ram_write_enable, bus.ram_data_in, 12'h0, bus.ram_address}, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.ram_write_enable) cnt++;
        end
        chk("abort_quiet", 32'(cnt), 32'd0);
        chk("abort_sb", 32'(sb.size()), 32'd0);
        mem_check("abort_mem");

        // start accepted on the first edge after reset release
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        run_op(1'b1, 9'h000, 9'h0C0, 9'd2, 8'h96, 3, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
